ultrasonic_array: RTL and testbench

- Time-multiplexed controller for N_CH HC-SR04 ultrasonic sensors. It fires one sensor at a time, round-robin, so there is never acoustic crosstalk.
- Per channel it measures echo width, converts it to centimetres and holds the last in-range reading per channel.
- Replaces the single-sensor front_sensor path plus the separate last-valid filter. It feeds motor_controller and the seven-segment selector with front/left/right distances.

---
 rtl/sonar_pkg.sv | 32 +++
 rtl/ultrasonic_array_if.sv | 35 +++
 rtl/sonar_echo_sync.sv | 33 +++
 rtl/ultrasonic_array.sv | 197 +++++++++++++++++++
 tb/tb_ultrasonic_array.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/sonar_pkg.sv
// Shared types and constants for the round-robin ultrasonic scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sonar_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG,
        ST_WAIT_RISE,
        ST_MEASURE,
        ST_GAP
    } state_t;

    // Round-trip sound travel time for one centimetre of range.
    localparam int US_PER_CM = 58;

    localparam int DEF_N_CH       = 3;
    localparam int DEF_CLK_HZ     = 125_000_000;
    localparam int DEF_DW         = 16;
    localparam int DEF_TRIG_US    = 10;
    localparam int DEF_TIMEOUT_US = 30_000;
    localparam int DEF_GAP_US     = 60_000;
    localparam int DEF_MIN_CM     = 2;
    localparam int DEF_MAX_CM     = 400;
    localparam int DEF_RESET_CM   = 25;

    // Channel index width; a single sensor still gets a 1-bit index.
    function automatic int ch_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ultrasonic_array_if.sv
// Sensor pins plus result bus of the ultrasonic scanner.
// Latency: n/a (wiring only).
// Backpressure: none; the consumer samples strobes and held registers.
interface ultrasonic_array_if
    import sonar_pkg::*;
#(
    parameter int N_CH = DEF_N_CH,
    parameter int DW   = DEF_DW
);

    localparam int CH_W = ch_width(N_CH);

    logic                 enable;
    logic [N_CH-1:0]      echo;
    logic [N_CH-1:0]      trig;
    logic [N_CH*DW-1:0]   distance;
    logic [N_CH-1:0]      valid;
    logic [N_CH-1:0]      timeout_err;
    logic                 sample_strobe;
    logic [CH_W-1:0]      sample_ch;
    logic [DW-1:0]        sample_cm;

    modport master (
        input  enable, echo,
        output trig, distance, valid, timeout_err,
               sample_strobe, sample_ch, sample_cm
    );

    modport slave (
        output enable, echo,
        input  trig, distance, valid, timeout_err,
               sample_strobe, sample_ch, sample_cm
    );

endinterface

// File: rtl/sonar_echo_sync.sv
// Per-bit 2-FF synchroniser for raw echo pins with rise/fall pulses.
// Latency: 2 clocks from pin to synchronised level; edges are one cycle wide.
// Backpressure: none.
module sonar_echo_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] async_i,
    output logic [W-1:0] rise_o,
    output logic [W-1:0] fall_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;
    logic [W-1:0] prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/ultrasonic_array.sv
// Round-robin HC-SR04 scanner: fires one sensor at a time, keeps last in-range cm per channel.
// Latency: trig rises 1 clock after IDLE is left; sample_strobe lands <= 3 clocks after echo falls.
// Backpressure: none; results are single-cycle strobes plus held per-channel registers.
module ultrasonic_array
    import sonar_pkg::*;
#(
    parameter int N_CH       = DEF_N_CH,
    parameter int CLK_HZ     = DEF_CLK_HZ,
    parameter int DW         = DEF_DW,
    parameter int TRIG_US    = DEF_TRIG_US,
    parameter int TIMEOUT_US = DEF_TIMEOUT_US,
    parameter int GAP_US     = DEF_GAP_US,
    parameter int MIN_CM     = DEF_MIN_CM,
    parameter int MAX_CM     = DEF_MAX_CM,
    parameter int RESET_CM   = DEF_RESET_CM
) (
    input  logic               clk_125mhz,
    input  logic               reset,
    ultrasonic_array_if.master bus
);

    localparam int            DIV     = CLK_HZ / 1_000_000;
    localparam int            CH_W    = ch_width(N_CH);
    localparam logic [DW-1:0] CM_ALL1 = {DW{1'b1}};

    logic [N_CH-1:0] echo_rise;
    logic [N_CH-1:0] echo_fall;

    sonar_echo_sync #(.W(N_CH)) u_echo_sync (
        .clk     (clk_125mhz),
        .rst_n   (reset),
        .async_i (bus.echo),
        .rise_o  (echo_rise),
        .fall_o  (echo_fall)
    );

    state_t                  state_q,  state_d;
    logic [CH_W-1:0]         ch_q,     ch_d;
    logic [31:0]             pre_q,    pre_d;
    logic [31:0]             us_q,     us_d;
    logic [5:0]              sub_q,    sub_d;
    logic [DW-1:0]           cm_q,     cm_d;
    logic [N_CH-1:0]         trig_q,   trig_d;
    logic [N_CH-1:0][DW-1:0] dist_q,   dist_d;
    logic [N_CH-1:0]         valid_q,  valid_d;
    logic [N_CH-1:0]         terr_q,   terr_d;
    logic                    strobe_q, strobe_d;
    logic [CH_W-1:0]         sch_q,    sch_d;
    logic [DW-1:0]           scm_q,    scm_d;

    logic          tick;
    logic          done;
    logic          timed_out;
    logic [DW-1:0] result;

    assign tick = (pre_q == 32'(DIV - 1));

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        pre_d     = tick ? '0 : pre_q + 32'd1;
        us_d      = tick ? us_q + 32'd1 : us_q;
        sub_d     = sub_q;
        cm_d      = cm_q;
        trig_d    = '0;
        dist_d    = dist_q;
        valid_d   = valid_q;
        terr_d    = terr_q;
        strobe_d  = 1'b0;
        sch_d     = sch_q;
        scm_d     = scm_q;
        done      = 1'b0;
        timed_out = 1'b0;
        result    = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.enable) begin
                    state_d      = ST_TRIG;
                    trig_d[ch_q] = 1'b1;
                end
            end
            ST_TRIG: begin
                if (tick && us_q == 32'(TRIG_US - 1)) begin
                    state_d = ST_WAIT_RISE;
                end else begin
                    trig_d[ch_q] = 1'b1;
                end
            end
            ST_WAIT_RISE: begin
                // Only a fresh edge counts, so a pin already high here runs out the timer.
                if (echo_rise[ch_q]) begin
                    state_d = ST_MEASURE;
                end else if (tick && us_q == 32'(TIMEOUT_US - 1)) begin
                    done      = 1'b1;
                    timed_out = 1'b1;
                end
            end
            ST_MEASURE: begin
                if (tick) begin
                    if (sub_q == 6'(US_PER_CM - 1)) begin
                        sub_d = '0;
                        cm_d  = (cm_q == CM_ALL1) ? cm_q : cm_q + 1'b1;
                    end else begin
                        sub_d = sub_q + 6'd1;
                    end
                end
                // A tick landing on the falling-edge cycle still counts toward the result.
                if (echo_fall[ch_q]) begin
                    done   = 1'b1;
                    result = cm_d;
                end else if (tick && us_q == 32'(TIMEOUT_US - 1)) begin
                    done      = 1'b1;
                    timed_out = 1'b1;
                end
            end
            ST_GAP: begin
                if (tick && us_q == 32'(GAP_US - 1)) begin
                    state_d = ST_IDLE;
                    ch_d    = (ch_q == CH_W'(N_CH - 1)) ? '0 : ch_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (done) begin
            state_d  = ST_GAP;
            strobe_d = 1'b1;
            sch_d    = ch_q;
            if (timed_out) begin
                scm_d         = CM_ALL1;
                valid_d[ch_q] = 1'b0;
                terr_d[ch_q]  = 1'b1;
            end else begin
                scm_d = result;
                if (result >= DW'(MIN_CM) && result <= DW'(MAX_CM)) begin
                    dist_d[ch_q]  = result;
                    valid_d[ch_q] = 1'b1;
                    terr_d[ch_q]  = 1'b0;
                end else begin
                    valid_d[ch_q] = 1'b0;
                end
            end
        end

        // Every state times itself from its own entry, so restart the timebase on any move.
        if (state_d != state_q) begin
            pre_d = '0;
            us_d  = '0;
            sub_d = '0;
            cm_d  = '0;
        end
    end

    always_ff @(posedge clk_125mhz or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            ch_q     <= '0;
            pre_q    <= '0;
            us_q     <= '0;
            sub_q    <= '0;
            cm_q     <= '0;
            trig_q   <= '0;
            dist_q   <= {N_CH{DW'(RESET_CM)}};
            valid_q  <= '0;
            terr_q   <= '0;
            strobe_q <= 1'b0;
            sch_q    <= '0;
            scm_q    <= '0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            pre_q    <= pre_d;
            us_q     <= us_d;
            sub_q    <= sub_d;
            cm_q     <= cm_d;
            trig_q   <= trig_d;
            dist_q   <= dist_d;
            valid_q  <= valid_d;
            terr_q   <= terr_d;
            strobe_q <= strobe_d;
            sch_q    <= sch_d;
            scm_q    <= scm_d;
        end
    end

    assign bus.trig          = trig_q;
    assign bus.distance      = dist_q;
    assign bus.valid         = valid_q;
    assign bus.timeout_err   = terr_q;
    assign bus.sample_strobe = strobe_q;
    assign bus.sample_ch     = sch_q;
    assign bus.sample_cm     = scm_q;

endmodule

// File: tb/tb_ultrasonic_array.sv
// Bench for ultrasonic_array: plays sensors that answer each trigger, predicts results from echo widths.
// Timing parameters are scaled down so the whole scan stays short.
module tb_ultrasonic_array;

    localparam int N_CH       = 3;
    localparam int CLK_HZ     = 2_000_000;
    localparam int DW         = 16;
    localparam int TRIG_US    = 10;
    localparam int TIMEOUT_US = 1300;
    localparam int GAP_US     = 150;
    localparam int MIN_CM     = 2;
    localparam int MAX_CM     = 20;
    localparam int RESET_CM   = 25;
    localparam int DIV        = CLK_HZ / 1_000_000;

    localparam int MODE_NORM  = 0;
    localparam int MODE_STUCK = 1;
    localparam int MODE_DROP  = 2;
    localparam int MODE_RESET = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    ultrasonic_array_if #(.N_CH(N_CH), .DW(DW)) bus ();

    ultrasonic_array #(
        .N_CH(N_CH), .CLK_HZ(CLK_HZ), .DW(DW), .TRIG_US(TRIG_US),
        .TIMEOUT_US(TIMEOUT_US), .GAP_US(GAP_US), .MIN_CM(MIN_CM),
        .MAX_CM(MAX_CM), .RESET_CM(RESET_CM)
    ) dut (
        .clk_125mhz (clk),
        .reset      (rst_n),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int multi_hot = 0;
    int exp_ch    = 0;
    int last_rise = -1;

    int m_dist  [N_CH];
    bit m_valid [N_CH];
    bit m_terr  [N_CH];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if ($countones(bus.trig) > 1) multi_hot++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N_CH; k++) begin
            m_dist[k]  = RESET_CM;
            m_valid[k] = 1'b0;
            m_terr[k]  = 1'b0;
        end
    endtask

    // w_us < 0 means the sensor never answered (or was stuck high).
    task automatic model_apply(input int ch, input int w_us, output int cm);
        if (w_us < 0 || w_us >= TIMEOUT_US) begin
            cm          = 16'hFFFF;
            m_valid[ch] = 1'b0;
            m_terr[ch]  = 1'b1;
        end else begin
            cm = w_us / 58;
            if (cm >= MIN_CM && cm <= MAX_CM) begin
                m_dist[ch]  = cm;
                m_valid[ch] = 1'b1;
                m_terr[ch]  = 1'b0;
            end else begin
                m_valid[ch] = 1'b0;
            end
        end
    endtask

    task automatic check_outputs(input string where);
        for (int k = 0; k < N_CH; k++) begin
            check($sformatf("%s_dist%0d", where, k), bus.distance[k*DW +: DW], m_dist[k]);
            check($sformatf("%s_valid%0d", where, k), bus.valid[k], m_valid[k]);
            check($sformatf("%s_terr%0d", where, k), bus.timeout_err[k], m_terr[k]);
        end
    endtask

    task automatic measure(input int w_us, input int dly_us, input int mode);
        int ch;
        int n;
        int cm;
        bit to;
        if (mode == MODE_STUCK) bus.echo[exp_ch] = 1'b1;

        n = 0;
        while (bus.trig == '0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        to = (bus.trig == '0);
        check("trig_arrives_timeout", to, 0);
        if (to) return;

        ch = 0;
        for (int k = 0; k < N_CH; k++) if (bus.trig[k]) ch = k;
        check("trig_order", ch, exp_ch);
        if (last_rise >= 0) check("trig_spacing_ge_gap", (cyc - last_rise) >= GAP_US * DIV, 1);
        last_rise = cyc;
        if (mode == MODE_DROP) bus.enable = 1'b0;

        n = 0;
        while (bus.trig[ch] && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check("trig_width", n, TRIG_US * DIV);

        if (mode != MODE_STUCK && w_us >= 0) begin
            repeat (dly_us * DIV) @(negedge clk);
            bus.echo[ch] = 1'b1;
            if (mode == MODE_RESET) begin
                repeat (200) @(negedge clk);
                rst_n = 1'b0;
                #1;
                model_reset();
                check("rst_trig", bus.trig, 0);
                check("rst_strobe", bus.sample_strobe, 0);
                check_outputs("rst_mid");
                bus.echo = '0;
                repeat (3) @(negedge clk);
                rst_n     = 1'b1;
                exp_ch    = 0;
                last_rise = -1;
                return;
            end
            repeat (w_us * DIV + 1) @(negedge clk);
            bus.echo[ch] = 1'b0;
        end

        n = 0;
        while (!bus.sample_strobe && n < 4 * TIMEOUT_US * DIV) begin
            @(negedge clk);
            n++;
        end
        to = !bus.sample_strobe;
        check("strobe_arrives_timeout", to, 0);
        if (to) return;
        if (mode != MODE_STUCK && w_us >= 0) check("strobe_latency_le3", n <= 3, 1);

        model_apply(exp_ch, (mode == MODE_STUCK) ? -1 : w_us, cm);
        check("sample_ch", bus.sample_ch, exp_ch);
        check("sample_cm", bus.sample_cm, cm);
        check_outputs("post");
        @(negedge clk);
        check("strobe_one_cycle", bus.sample_strobe, 0);

        if (mode == MODE_STUCK) bus.echo = '0;
        if (mode == MODE_DROP) begin
            n = 0;
            repeat ((GAP_US + 100) * DIV) begin
                @(negedge clk);
                if (bus.trig != '0) n++;
            end
            check("parked_no_trig", n, 0);
            bus.enable = 1'b1;
        end
        exp_ch = (exp_ch + 1) % N_CH;
    endtask

    initial begin
        int w;
        bus.enable = 1'b0;
        bus.echo   = '0;
        model_reset();
        repeat (3) @(negedge clk);

        check("reset_trig", bus.trig, 0);
        check("reset_strobe", bus.sample_strobe, 0);
        check("reset_sample_ch", bus.sample_ch, 0);
        check("reset_sample_cm", bus.sample_cm, 0);
        check_outputs("reset");

        bus.enable = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        measure(1160, 500, MODE_NORM);   // ch0: 20 cm, top of range
        measure(-1,   0,   MODE_NORM);   // ch1: no echo -> timeout
        measure(116,  50,  MODE_NORM);   // ch2: 2 cm, bottom of range
        measure(58,   50,  MODE_NORM);   // ch0: 1 cm rejected, 20 held
        measure(580,  50,  MODE_NORM);   // ch1: 10 cm clears timeout_err
        measure(0,    0,   MODE_STUCK);  // ch2: stuck-high echo
        measure(1218, 50,  MODE_NORM);   // ch0: 21 cm rejected
        measure(1160, 50,  MODE_NORM);   // ch1: 20 cm
        measure(300,  50,  MODE_NORM);   // ch2: 5 cm clears timeout_err

        for (int i = 0; i < 3; i++) begin
            w = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(1, 1250));
            measure(w, int'($urandom_range(5, 100)), MODE_NORM);
        end

        measure(400, 40, MODE_DROP);     // ch0: enable dropped during trigger
        measure(800, 40, MODE_RESET);    // ch1: reset during MEASURE
        measure(870, 40, MODE_NORM);     // scan restarts at ch0: 15 cm

        check("trig_onehot_violations", multi_hot, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
